rf_write_arbiter: RTL and testbench

Shares the register file's single write port between two write-back requesters: execute-stage results (port A, younger instruction) and memory-stage load results (port B, older instruction). Each requester gets a one-entry holding slot with a valid/ready handshake. A round-robin arbiter with same-register ordering protection drives a registered write port, which feeds the register file's 4-to-16 write decoder. A per-register pending bitmap is exported for hazard detection.

---
 rtl/rf_wb_pkg.sv | 23 ++
 rtl/wb_hold_slot.sv | 32 +++
 rtl/rf_write_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// The slot struct pairs a destination register with its write data.
package rf_wb_pkg;

    localparam int DATA_W = 16;
    localparam int NREG   = 16;
    localparam int REG_W  = $clog2(NREG);

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    typedef struct packed {
        logic [REG_W-1:0]  regno;
        logic [DATA_W-1:0] data;
    } wb_slot_t;

    function automatic logic [NREG-1:0] reg_bit(input logic [REG_W-1:0] r);
        return {{(NREG-1){1'b0}}, 1'b1} << r;
    endfunction

endpackage

// File: rtl/wb_hold_slot.sv
// One-entry holding register for a write-back requester.
// Writes to R0 are accepted but dropped, since R0 is hardwired zero.
module wb_hold_slot
    import rf_wb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     req_valid,
    output logic     req_ready,
    input  wb_slot_t req_slot,
    input  logic     drain,
    output logic     loaded,
    output logic     held,
    output wb_slot_t slot
);

    assign req_ready = rst_n & (~held | drain);
    assign loaded    = req_valid & req_ready & (req_slot.regno != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held <= 1'b0;
            slot <= '0;
        end else if (loaded) begin
            held <= 1'b1;
            slot <= req_slot;
        end else if (drain) begin
            held <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two write-back requesters onto the register file's single
// write port, keeping same-register writes in program order.
module rf_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    localparam int REG_W = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_W-1:0]  a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_W-1:0]  b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              wr_en,
    output logic [REG_W-1:0]  wr_reg,
    output logic [DATA_W-1:0] wr_data,
    output logic [NREG-1:0]   pending
);
    import rf_wb_pkg::*;

    wb_slot_t slot_a, slot_b;
    wb_slot_t req_a, req_b;
    logic     held_a, held_b;
    logic     load_a, load_b;
    logic     grant_a, grant_b;
    logic     contested;
    logic     a_older;
    req_id_e  last_grant;

    assign req_a = '{regno: a_reg, data: a_data};
    assign req_b = '{regno: b_reg, data: b_data};

    wb_hold_slot u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (a_valid),
        .req_ready (a_ready),
        .req_slot  (req_a),
        .drain     (grant_a),
        .loaded    (load_a),
        .held      (held_a),
        .slot      (slot_a)
    );

    wb_hold_slot u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (b_valid),
        .req_ready (b_ready),
        .req_slot  (req_b),
        .drain     (grant_b),
        .loaded    (load_b),
        .held      (held_b),
        .slot      (slot_b)
    );

    // Same-register pairs bypass round-robin so the older write lands first.
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        contested = 1'b0;
        if (held_a && held_b) begin
            if (slot_a.regno == slot_b.regno) begin
                grant_a = a_older;
                grant_b = ~a_older;
            end else begin
                contested = 1'b1;
                grant_a   = (last_grant == REQ_B);
                grant_b   = (last_grant == REQ_A);
            end
        end else begin
            grant_a = held_a;
            grant_b = held_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= REQ_A;
            a_older    <= 1'b0;
        end else begin
            if (contested) begin
                last_grant <= grant_a ? REQ_A : REQ_B;
            end
            // Age only matters while both slots are held afterwards.
            if (load_a && load_b) begin
                a_older <= 1'b0;
            end else if (load_a && held_b && !grant_b) begin
                a_older <= 1'b0;
            end else if (load_b && held_a && !grant_a) begin
                a_older <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= grant_a | grant_b;
            if (grant_a) begin
                wr_reg  <= slot_a.regno;
                wr_data <= slot_a.data;
            end else if (grant_b) begin
                wr_reg  <= slot_b.regno;
                wr_data <= slot_b.data;
            end
        end
    end

    always_comb begin
        pending = '0;
        if (held_a) pending = pending | reg_bit(slot_a.regno);
        if (held_b) pending = pending | reg_bit(slot_b.regno);
        if (wr_en)  pending = pending | reg_bit(wr_reg);
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction model.
module tb_rf_write_arbiter;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic          a_ready, b_ready;
    logic [RW-1:0] a_reg = '0, b_reg = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          wr_en;
    logic [RW-1:0] wr_reg;
    logic [DW-1:0] wr_data;
    logic [NR-1:0] pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.DATA_W(DW), .NREG(NR)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_reg   (a_reg),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_reg   (b_reg),
        .b_data  (b_data),
        .wr_en   (wr_en),
        .wr_reg  (wr_reg),
        .wr_data (wr_data),
        .pending (pending)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each port holds at most one write stamped with an acceptance
    // sequence number; older = smaller stamp (B stamped first on a tie).
    bit            m_hold [2];
    logic [RW-1:0] m_reg  [2];
    logic [DW-1:0] m_data [2];
    int            m_seq  [2];
    int            seq_cnt = 0;
    bit            m_last = 1'b0;
    logic          m_wr_en = 1'b0;
    logic [RW-1:0] m_wr_reg = '0;
    logic [DW-1:0] m_wr_data = '0;

    function automatic logic [1:0] mgrant();
        if (m_hold[0] && m_hold[1]) begin
            if (m_reg[0] == m_reg[1])
                return (m_seq[0] < m_seq[1]) ? 2'b01 : 2'b10;
            return (m_last == 1'b0) ? 2'b10 : 2'b01;
        end
        return {m_hold[1], m_hold[0]};
    endfunction

    initial begin
        logic [1:0] g;
        bit acc_a, acc_b, both_differ;
        int k;
        m_hold[0] = 0; m_hold[1] = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_hold[0] = 0; m_hold[1] = 0;
                m_wr_en = 0; m_wr_reg = '0; m_wr_data = '0;
                m_last = 0;
            end else begin
                g = mgrant();
                acc_a = a_valid && (!m_hold[0] || g[0]) && (a_reg != 0);
                acc_b = b_valid && (!m_hold[1] || g[1]) && (b_reg != 0);
                both_differ = m_hold[0] && m_hold[1] && (m_reg[0] != m_reg[1]);
                k = g[1] ? 1 : 0;
                m_wr_en = (g != 2'b00);
                if (g != 2'b00) begin
                    m_wr_reg  = m_reg[k];
                    m_wr_data = m_data[k];
                end
                if (both_differ) m_last = k[0];
                if (g[0]) m_hold[0] = 0;
                if (g[1]) m_hold[1] = 0;
                if (acc_b) begin
                    m_hold[1] = 1; m_reg[1] = b_reg; m_data[1] = b_data; m_seq[1] = seq_cnt++;
                end
                if (acc_a) begin
                    m_hold[0] = 1; m_reg[0] = a_reg; m_data[0] = a_data; m_seq[0] = seq_cnt++;
                end
            end
        end
    end

    initial begin
        logic [1:0] g;
        logic [NR-1:0] ep;
        forever begin
            @(negedge clk);
            g = mgrant();
            ep = '0;
            if (m_hold[0]) ep[m_reg[0]] = 1'b1;
            if (m_hold[1]) ep[m_reg[1]] = 1'b1;
            if (m_wr_en) ep[m_wr_reg] = 1'b1;
            ep[0] = 1'b0;
            chk("m_a_ready", a_ready, rst_n & (!m_hold[0] | g[0]));
            chk("m_b_ready", b_ready, rst_n & (!m_hold[1] | g[1]));
            chk("m_wr_en",   wr_en,   m_wr_en);
            chk("m_wr_reg",  wr_reg,  m_wr_reg);
            chk("m_wr_data", wr_data, m_wr_data);
            chk("m_pending", pending, ep);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_a(input logic v, input logic [RW-1:0] r, input logic [DW-1:0] d);
        a_valid = v; a_reg = r; a_data = d;
    endtask

    task automatic set_b(input logic v, input logic [RW-1:0] r, input logic [DW-1:0] d);
        b_valid = v; b_reg = r; b_data = d;
    endtask

    task automatic do_reset();
        a_valid = 0; b_valid = 0;
        rst_n = 0;
        step(); step();
        rst_n = 1;
        step();
    endtask

    initial begin
        int ia, ib, pulses, first, last, cyc;
        logic [DW-1:0] seen [$];
        logic [DW-1:0] expv;
        bit keep_a, keep_b;

        // Single requester
        do_reset();
        set_a(1, 4'd3, 16'h1234);
        step();
        a_valid = 0;
        chk("single_c1_pend", pending, 16'h0008);
        chk("single_c1_wren", wr_en, 0);
        step();
        chk("single_c2_wren", wr_en, 1);
        chk("single_c2_reg", wr_reg, 3);
        chk("single_c2_data", wr_data, 16'h1234);
        chk("single_c2_pend", pending, 16'h0008);
        step();
        chk("single_c3_pend", pending, 16'h0000);
        chk("single_c3_wren", wr_en, 0);

        // Contested, distinct registers
        do_reset();
        set_a(1, 4'd1, 16'h0001);
        set_b(1, 4'd2, 16'h0002);
        step();
        chk("cont_c1_a_ready", a_ready, 0);
        chk("cont_c1_b_ready", b_ready, 1);
        a_valid = 0; b_valid = 0;
        step();
        chk("cont_c2_reg", wr_reg, 2);
        chk("cont_c2_data", wr_data, 16'h0002);
        step();
        chk("cont_c3_reg", wr_reg, 1);
        chk("cont_c3_data", wr_data, 16'h0001);
        step();
        set_a(1, 4'd3, 16'h0033);
        set_b(1, 4'd4, 16'h0044);
        step();
        a_valid = 0; b_valid = 0;
        step();
        chk("cont2_first_reg", wr_reg, 3);
        step();
        chk("cont2_second_reg", wr_reg, 4);

        // Same register, staggered acceptance
        do_reset();
        set_a(1, 4'd7, 16'h7777);
        set_b(1, 4'd6, 16'h6666);
        step();
        chk("same1_c1_a_ready", a_ready, 0);
        a_valid = 0;
        set_b(1, 4'd5, 16'hAAAA);
        step();
        chk("same1_c2_data", wr_data, 16'h6666);
        chk("same1_c2_b_ready", b_ready, 0);
        b_valid = 0;
        set_a(1, 4'd5, 16'hBBBB);
        step();
        a_valid = 0;
        chk("same1_c3_data", wr_data, 16'h7777);
        step();
        chk("same1_c4_reg", wr_reg, 5);
        chk("same1_c4_data", wr_data, 16'hAAAA);
        step();
        chk("same1_c5_data", wr_data, 16'hBBBB);
        chk("same1_c5_pend", pending, 16'h0020);
        step();
        chk("same1_c6_pend", pending, 16'h0000);

        // Same register, same edge
        do_reset();
        set_a(1, 4'd5, 16'hBBBB);
        set_b(1, 4'd5, 16'hAAAA);
        step();
        a_valid = 0; b_valid = 0;
        step();
        chk("same2_c2_data", wr_data, 16'hAAAA);
        step();
        chk("same2_c3_data", wr_data, 16'hBBBB);
        step();
        chk("same2_c4_wren", wr_en, 0);

        // R0 discard
        do_reset();
        set_a(1, 4'd0, 16'hFFFF);
        step();
        chk("r0_a_ready", a_ready, 1);
        a_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("r0_wren", wr_en, 0);
            chk("r0_pend", pending, 0);
            step();
        end

        // Streaming with backpressure
        do_reset();
        ia = 0; ib = 0; pulses = 0; first = -1; last = -1; cyc = 0;
        set_a(1, 4'd1, 16'hA000);
        set_b(1, 4'd9, 16'hB000);
        repeat (40) begin
            keep_a = a_valid && a_ready;
            keep_b = b_valid && b_ready;
            step();
            cyc++;
            if (cyc == 1) chk("stream_a_backpressure", a_ready, 0);
            if (wr_en) begin
                pulses++;
                if (first < 0) first = cyc;
                last = cyc;
                seen.push_back(wr_data);
            end
            if (keep_a) begin
                ia++;
                if (ia < 8) set_a(1, 4'(ia + 1), 16'hA000 | 16'(ia));
                else a_valid = 0;
            end
            if (keep_b) begin
                ib++;
                if (ib < 8) set_b(1, (ib < 7) ? 4'(9 + ib) : 4'd1, 16'hB000 | 16'(ib));
                else b_valid = 0;
            end
        end
        chk("stream_pulses", pulses, 16);
        chk("stream_span", last - first, 15);
        for (int i = 0; i < seen.size(); i++) begin
            expv = ((i % 2) == 0) ? (16'hB000 | 16'(i / 2)) : (16'hA000 | 16'(i / 2));
            chk("stream_order", seen[i], expv);
        end

        // Reset mid-flight
        do_reset();
        set_a(1, 4'd3, 16'h3333);
        set_b(1, 4'd4, 16'h4444);
        step();
        a_valid = 0; b_valid = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        #1;
        chk("rst_wren", wr_en, 0);
        chk("rst_pend", pending, 0);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_b_ready", b_ready, 1);
        repeat (4) begin
            step();
            chk("rst_no_commit", wr_en, 0);
        end

        // Randomized traffic against the model
        do_reset();
        repeat (3000) begin
            keep_a = a_valid && !a_ready;
            keep_b = b_valid && !b_ready;
            rst_n = ($urandom_range(0, 299) != 0);
            if (!keep_a) begin
                a_valid = ($urandom_range(0, 2) != 0);
                a_reg   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
                a_data  = 16'($urandom);
            end
            if (!keep_b) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_reg   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
                b_data  = 16'($urandom);
            end
            step();
        end
        rst_n = 1;
        a_valid = 0; b_valid = 0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
